slave_port_initiator: RTL

//  Synthesizable initiator for the two-channel slave memory port of an HLS-generated top (S_oe_ram/S_we_ram/...).

---
 rtl/slave_port_initiator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/slave_port_initiator.sv
// Request/response bridge onto the two-channel slave memory port of an HLS top.
// One transaction in flight; each slave cycle is bounded by a DataRdy timeout.
module slave_port_initiator #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_ch,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [SIZE_W-1:0]     req_size,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic [15:0]           txn_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  // Last strobe cycle index before giving up (counter starts at 0).
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                ch_q, ch_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [15:0]         tmo_q, tmo_d;
  logic [15:0]         txn_q, txn_d;

  logic                rdy_sel;
  logic [DATA_W-1:0]   rdata_sel;

  assign rdy_sel   = Sout_DataRdy[ch_q];
  assign rdata_sel = ch_q ? Sout_Rdata_ram[2*DATA_W-1:DATA_W] : Sout_Rdata_ram[DATA_W-1:0];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    we_d      = we_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    txn_d     = txn_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = !core_busy && !reset;
        if (req_valid && req_ready) begin
          we_d    = req_we;
          ch_d    = req_ch;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          tmo_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + 16'd1;
        // DataRdy is checked first so a completion on the timeout edge still succeeds.
        if (rdy_sel) begin
          rdata_d = we_q ? '0 : rdata_sel;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          txn_d   = txn_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = '0;
    if (state_q == ISSUE) begin
      if (we_q) S_we_ram[ch_q] = 1'b1;
      else      S_oe_ram[ch_q] = 1'b1;
      if (ch_q) begin
        S_addr_ram[2*ADDR_W-1:ADDR_W]      = addr_q;
        S_Wdata_ram[2*DATA_W-1:DATA_W]     = we_q ? wdata_q : '0;
        S_data_ram_size[2*SIZE_W-1:SIZE_W] = size_q;
      end else begin
        S_addr_ram[ADDR_W-1:0]      = addr_q;
        S_Wdata_ram[DATA_W-1:0]     = we_q ? wdata_q : '0;
        S_data_ram_size[SIZE_W-1:0] = size_q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ch_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      txn_q   <= txn_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_count = txn_q;

endmodule
